// File: rtl/ram512_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram512_port_arbiter
//  Description : Single-port access controller for a 512 x 16 RAM. Two
//                requesters share the RAM through a round-robin valid/ready
//                arbiter. Read data is returned registered one cycle after
//                the accept edge. A clear engine zero-fills every location
//                on command.
//  Revision    : 1.0  initial release
// ============================================================================
module ram512_port_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              clear_req,
    output logic              clear_busy,

    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic              req_we_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    output logic              rsp_valid_0,
    output logic [DATA_W-1:0] rsp_rdata_0,

    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic              req_we_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_rdata_1,

    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);

    // Controller states
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_CLEAR = 1'b1;

    // Last address written by the clear sweep
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_ptr;      // 0: port 0 wins a tie, 1: port 1 wins

    logic              w_accept_ok;
    logic              w_grant_0;
    logic              w_grant_1;
    logic              w_xfer_0;
    logic              w_xfer_1;
    logic              w_sweep;

    // Arbitration: only in IDLE, never while reset or a clear command is seen
    always_comb begin
        w_accept_ok = !reset && (r_state == c_IDLE) && !clear_req;
        w_grant_0   = req_valid_0 && (!req_valid_1 || !r_ptr);
        w_grant_1   = req_valid_1 && (!req_valid_0 ||  r_ptr);
        req_ready_0 = w_accept_ok && w_grant_0;
        req_ready_1 = w_accept_ok && w_grant_1;
        // ready already implies valid, so ready alone marks a transfer
        w_xfer_0    = req_ready_0;
        w_xfer_1    = req_ready_1;
        // The sweep stops driving the RAM as soon as reset is raised
        w_sweep     = !reset && (r_state == c_CLEAR);
        clear_busy  = (r_state == c_CLEAR);
    end

    // RAM drive: clear sweep, granted port, or a quiet bus
    always_comb begin
        ram_load    = 1'b0;
        ram_address = '0;
        ram_in      = '0;
        if (w_sweep) begin
            ram_load    = 1'b1;
            ram_address = r_cnt;
        end else if (w_xfer_0) begin
            ram_load    = req_we_0;
            ram_address = req_addr_0;
            ram_in      = req_wdata_0;
        end else if (w_xfer_1) begin
            ram_load    = req_we_1;
            ram_address = req_addr_1;
            ram_in      = req_wdata_1;
        end
    end

    // State machine and clear counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (clear_req) begin
                        r_state <= c_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                c_CLEAR: begin
                    if (r_cnt == c_LAST) begin
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Round-robin pointer: hand priority to the other port after a transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (w_xfer_0) begin
            r_ptr <= 1'b1;
        end else if (w_xfer_1) begin
            r_ptr <= 1'b0;
        end
    end

    // Read response for port 0: capture RAM data on the accept edge
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_0 <= 1'b0;
            rsp_rdata_0 <= '0;
        end else begin
            rsp_valid_0 <= w_xfer_0 && !req_we_0;
            if (w_xfer_0 && !req_we_0) begin
                rsp_rdata_0 <= ram_out;
            end
        end
    end

    // Read response for port 1: capture RAM data on the accept edge
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_1 <= 1'b0;
            rsp_rdata_1 <= '0;
        end else begin
            rsp_valid_1 <= w_xfer_1 && !req_we_1;
            if (w_xfer_1 && !req_we_1) begin
                rsp_rdata_1 <= ram_out;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram512_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram512_port_arbiter
//  Description : Directed bench for ram512_port_arbiter with a behavioural
//                512 x 16 RAM attached to the RAM-side ports.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram512_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_req;
    logic        clear_busy;
    logic        req_valid_0, req_ready_0, req_we_0;
    logic [8:0]  req_addr_0;
    logic [15:0] req_wdata_0;
    logic        rsp_valid_0;
    logic [15:0] rsp_rdata_0;
    logic        req_valid_1, req_ready_1, req_we_1;
    logic [8:0]  req_addr_1;
    logic [15:0] req_wdata_1;
    logic        rsp_valid_1;
    logic [15:0] rsp_rdata_1;
    logic [15:0] ram_in;
    logic [8:0]  ram_address;
    logic        ram_load;
    logic [15:0] ram_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, combinational read
    logic [15:0] mem [0:511];
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    end
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
    end
    assign ram_out = mem[ram_address];

    ram512_port_arbiter #(.DATA_W(16), .ADDR_W(9), .DEPTH(512)) dut (
        .clk(clk), .reset(reset),
        .clear_req(clear_req), .clear_busy(clear_busy),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
        .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
        .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
        .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
        .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
        .ram_in(ram_in), .ram_address(ram_address), .ram_load(ram_load),
        .ram_out(ram_out)
    );

    typedef struct {
        logic        v0, w0;
        logic [8:0]  a0;
        logic [15:0] d0;
        logic        v1, w1;
        logic [8:0]  a1;
        logic [15:0] d1;
        logic        er0, er1, eload;
        logic [8:0]  eaddr;
        logic [15:0] ein;
        logic        erv0;
        logic [15:0] erd0;
        logic        erv1;
        logic [15:0] erd1;
    } vec_t;

    function automatic vec_t mk(
        input logic v0, input logic w0, input logic [8:0] a0, input logic [15:0] d0,
        input logic v1, input logic w1, input logic [8:0] a1, input logic [15:0] d1,
        input logic er0, input logic er1, input logic eload,
        input logic [8:0] eaddr, input logic [15:0] ein,
        input logic erv0, input logic [15:0] erd0,
        input logic erv1, input logic [15:0] erd1);
        vec_t v;
        v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.er0 = er0; v.er1 = er1; v.eload = eload; v.eaddr = eaddr; v.ein = ein;
        v.erv0 = erv0; v.erd0 = erd0; v.erv1 = erv1; v.erd1 = erd1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear_req   = 1'b0;
        req_valid_0 = 1'b0; req_we_0 = 1'b0; req_addr_0 = '0; req_wdata_0 = '0;
        req_valid_1 = 1'b0; req_we_1 = 1'b0; req_addr_1 = '0; req_wdata_1 = '0;
    endtask

    vec_t vt [0:16];

    initial begin
        int low, busy, sweep_err;
        bit done;

        vt[0]  = mk(0,0,9'h000,16'h0000, 0,0,9'h000,16'h0000, 0,0,0,9'h000,16'h0000, 0,16'h0000,0,16'h0000);
        vt[1]  = mk(1,1,9'h005,16'hBEEF, 0,0,9'h000,16'h0000, 1,0,1,9'h005,16'hBEEF, 0,16'h0000,0,16'h0000);
        vt[2]  = mk(1,0,9'h005,16'h0000, 0,0,9'h000,16'h0000, 1,0,0,9'h005,16'h0000, 0,16'h0000,0,16'h0000);
        vt[3]  = mk(0,0,9'h000,16'h0000, 0,0,9'h000,16'h0000, 0,0,0,9'h000,16'h0000, 1,16'hBEEF,0,16'h0000);
        vt[4]  = mk(0,0,9'h000,16'h0000, 0,0,9'h000,16'h0000, 0,0,0,9'h000,16'h0000, 0,16'hBEEF,0,16'h0000);
        vt[5]  = mk(0,0,9'h000,16'h0000, 1,1,9'h000,16'hA5A5, 0,1,1,9'h000,16'hA5A5, 0,16'hBEEF,0,16'h0000);
        vt[6]  = mk(1,1,9'h1FF,16'h5A5A, 0,0,9'h000,16'h0000, 1,0,1,9'h1FF,16'h5A5A, 0,16'hBEEF,0,16'h0000);
        vt[7]  = mk(1,0,9'h1FF,16'h0000, 1,0,9'h000,16'h0000, 0,1,0,9'h000,16'h0000, 0,16'hBEEF,0,16'h0000);
        vt[8]  = mk(1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 1,0,0,9'h1FF,16'h0000, 0,16'hBEEF,1,16'hA5A5);
        vt[9]  = mk(0,0,9'h000,16'h0000, 1,1,9'h010,16'h1111, 0,1,1,9'h010,16'h1111, 1,16'h5A5A,0,16'hA5A5);
        vt[10] = mk(0,0,9'h000,16'h0000, 1,0,9'h010,16'h0000, 0,1,0,9'h010,16'h0000, 0,16'h5A5A,0,16'hA5A5);
        vt[11] = mk(0,0,9'h000,16'h0000, 0,0,9'h000,16'h0000, 0,0,0,9'h000,16'h0000, 0,16'h5A5A,1,16'h1111);
        vt[12] = mk(1,1,9'h020,16'h0002, 1,1,9'h021,16'h0003, 1,0,1,9'h020,16'h0002, 0,16'h5A5A,0,16'h1111);
        vt[13] = mk(0,0,9'h000,16'h0000, 1,1,9'h021,16'h0003, 0,1,1,9'h021,16'h0003, 0,16'h5A5A,0,16'h1111);
        vt[14] = mk(0,0,9'h000,16'h0000, 0,0,9'h000,16'h0000, 0,0,0,9'h000,16'h0000, 0,16'h5A5A,0,16'h1111);
        vt[15] = mk(1,0,9'h021,16'h7777, 0,0,9'h000,16'h0000, 1,0,0,9'h021,16'h7777, 0,16'h5A5A,0,16'h1111);
        vt[16] = mk(0,0,9'h000,16'h0000, 0,0,9'h000,16'h0000, 0,0,0,9'h000,16'h0000, 1,16'h0003,0,16'h1111);

        // ---------------- reset state ----------------
        idle_inputs();
        reset = 1'b1;
        step();
        req_valid_0 = 1'b1; req_we_0 = 1'b1; req_valid_1 = 1'b1;
        #4;
        chk("rst_ready0", req_ready_0, 0);
        chk("rst_ready1", req_ready_1, 0);
        chk("rst_load", ram_load, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_rv0", rsp_valid_0, 0);
        chk("rst_rv1", rsp_valid_1, 0);
        chk("rst_rd0", rsp_rdata_0, 0);
        chk("rst_rd1", rsp_rdata_1, 0);
        step();
        reset = 1'b0;
        idle_inputs();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 17; i++) begin
            step();
            req_valid_0 = vt[i].v0; req_we_0 = vt[i].w0; req_addr_0 = vt[i].a0; req_wdata_0 = vt[i].d0;
            req_valid_1 = vt[i].v1; req_we_1 = vt[i].w1; req_addr_1 = vt[i].a1; req_wdata_1 = vt[i].d1;
            #4;
            chk($sformatf("v%0d_ready0", i), req_ready_0, vt[i].er0);
            chk($sformatf("v%0d_ready1", i), req_ready_1, vt[i].er1);
            chk($sformatf("v%0d_load", i), ram_load, vt[i].eload);
            chk($sformatf("v%0d_addr", i), ram_address, vt[i].eaddr);
            chk($sformatf("v%0d_in", i), ram_in, vt[i].ein);
            chk($sformatf("v%0d_rv0", i), rsp_valid_0, vt[i].erv0);
            chk($sformatf("v%0d_rd0", i), rsp_rdata_0, vt[i].erd0);
            chk($sformatf("v%0d_rv1", i), rsp_valid_1, vt[i].erv1);
            chk($sformatf("v%0d_rd1", i), rsp_rdata_1, vt[i].erd1);
            chk($sformatf("v%0d_busy", i), clear_busy, 0);
        end

        // ---------------- contention right after reset ----------------
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            req_valid_0 = (i < 4); req_addr_0 = 9'h1FF;
            req_valid_1 = (i < 4); req_addr_1 = 9'h010;
            #4;
            if (i < 4) begin
                chk($sformatf("cont%0d_ready0", i), req_ready_0, (i % 2 == 0));
                chk($sformatf("cont%0d_ready1", i), req_ready_1, (i % 2 == 1));
            end
            if (i == 0) begin
                chk("cont0_rv0", rsp_valid_0, 0);
                chk("cont0_rv1", rsp_valid_1, 0);
            end else begin
                chk($sformatf("cont%0d_rv0", i), rsp_valid_0, ((i - 1) % 2 == 0));
                chk($sformatf("cont%0d_rv1", i), rsp_valid_1, ((i - 1) % 2 == 1));
                if ((i - 1) % 2 == 0) chk($sformatf("cont%0d_rd0", i), rsp_rdata_0, 16'h5A5A);
                else                  chk($sformatf("cont%0d_rd1", i), rsp_rdata_1, 16'h1111);
            end
        end

        // ---------------- clear with a pending read ----------------
        for (int i = 0; i < 3; i++) begin
            step();
            idle_inputs();
            req_valid_0 = 1'b1; req_we_0 = 1'b1; req_wdata_0 = 16'h1234;
            req_addr_0  = (i == 0) ? 9'h000 : ((i == 1) ? 9'h0FF : 9'h1FF);
            #4;
            chk($sformatf("pre%0d_ready0", i), req_ready_0, 1);
        end
        step();
        idle_inputs();
        #4;
        chk("pre_mem255", mem[255], 16'h1234);
        low = 0; busy = 0; sweep_err = 0; done = 0;
        for (int k = 0; k < 600 && !done; k++) begin
            if (k > 0) step();
            clear_req   = (k == 0);
            req_valid_1 = 1'b1; req_we_1 = 1'b0; req_addr_1 = 9'h0FF;
            #4;
            if (k == 0) chk("clr_sample_load", ram_load, 0);
            if (req_ready_1) begin
                done = 1;
            end else begin
                low++;
                if (clear_busy) begin
                    busy++;
                    if (!(ram_load === 1'b1 && ram_in === 16'h0000 && ram_address === 9'(busy - 1)))
                        sweep_err++;
                end
            end
        end
        chk("clr_granted", done, 1);
        chk("clr_ready_low_cycles", low, 513);
        chk("clr_busy_cycles", busy, 512);
        chk("clr_sweep_drive_errs", sweep_err, 0);
        step();
        idle_inputs();
        #4;
        chk("clr_rv1", rsp_valid_1, 1);
        chk("clr_rd1", rsp_rdata_1, 16'h0000);
        chk("clr_mem0", mem[0], 16'h0000);
        chk("clr_mem511", mem[511], 16'h0000);

        // ---------------- reset in the middle of a clear ----------------
        step();
        clear_req = 1'b1;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            step();
            clear_req = 1'b0;
            #4;
            if (clear_busy && ram_address == 9'd100) done = 1;
        end
        chk("mid_reached100", done, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_load", ram_load, 0);
        step();
        chk("mid_busy_after", clear_busy, 0);
        reset = 1'b0;
        req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 9'h030; req_wdata_0 = 16'hCAFE;
        #4;
        chk("mid_accept_ready0", req_ready_0, 1);
        chk("mid_accept_load", ram_load, 1);
        step();
        req_we_0 = 1'b0; req_wdata_0 = 16'h0000;
        #4;
        chk("mid_read_ready0", req_ready_0, 1);
        step();
        idle_inputs();
        #4;
        chk("mid_rv0", rsp_valid_0, 1);
        chk("mid_rd0", rsp_rdata_0, 16'hCAFE);

        // ---------------- reset on the accept edge of a read ----------------
        step();
        reset = 1'b1;
        req_valid_0 = 1'b1; req_we_0 = 1'b0; req_addr_0 = 9'h030;
        #4;
        chk("rr_ready0", req_ready_0, 0);
        step();
        reset = 1'b0;
        idle_inputs();
        #4;
        chk("rr_rv0", rsp_valid_0, 0);
        chk("rr_rd0", rsp_rdata_0, 16'h0000);
        step();
        #4;
        chk("rr_rv0_late", rsp_valid_0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
